btn_gesture: RTL and testbench

- Downstream of the button debouncer in the super_counter path.
- Consumes the debouncer's one-cycle rising-edge pulse and its debounced level.
- Classifies each gesture as single click, double click or long press, and emits auto-repeat pulses while a long press is held.
- All event outputs are registered, one-cycle pulses that the counter logic consumes directly.

---
 rtl/btn_gesture.sv | 123 ++++++++++++
 tb/tb_btn_gesture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_gesture.sv
// Button gesture classifier: turns debounced press pulses and level into
// single / double / long-press events plus auto-repeat ticks for the counter.
module btn_gesture #(
  parameter int LONG_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pressed,
  input  logic btn_level,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_active
);

  localparam int MAX_A      = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    WAIT2,
    HELD2,
    LONG
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Pulses default low every cycle; long_active is rebuilt from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      long_active  <= 1'b0;
    end else begin
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      long_active  <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_pressed) begin
            state <= HELD1;
            timer <= '0;
          end
        end

        // Release wins over reaching the long-press threshold on the same edge.
        HELD1: begin
          if (!btn_level) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state       <= LONG;
            timer       <= '0;
            long_pulse  <= 1'b1;
            long_active <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // A press on the final gap cycle still counts as a double click.
        WAIT2: begin
          if (btn_pressed) begin
            state <= HELD2;
            timer <= '0;
          end else if (timer == GAP_LAST) begin
            state        <= IDLE;
            timer        <= '0;
            single_pulse <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        HELD2: begin
          if (!btn_level) begin
            state        <= IDLE;
            timer        <= '0;
            double_pulse <= 1'b1;
          end
        end

        LONG: begin
          if (!btn_level) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            long_active <= 1'b1;
            if (timer == REPEAT_LAST) begin
              timer        <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_gesture.sv
// Scoreboard bench for btn_gesture: directed gestures push expected events,
// a negedge monitor pops and compares each event the DUT produces.
module tb_btn_gesture;

  localparam int EV_SINGLE = 0;
  localparam int EV_DOUBLE = 1;
  localparam int EV_LONG   = 2;
  localparam int EV_REPEAT = 3;
  localparam int EV_LA_ON  = 4;
  localparam int EV_LA_OFF = 5;

  typedef struct {
    int kind;
    int stamp;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_pressed;
  logic btn_level;
  logic single_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic long_active;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   base;
  logic mon_en = 1'b0;
  logic prev_la = 1'b0;
  evt_t exp_q[$];
  int   obs[$];

  btn_gesture #(
    .LONG_CYCLES(8),
    .GAP_CYCLES(4),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pressed(btn_pressed),
    .btn_level(btn_level),
    .single_pulse(single_pulse),
    .double_pulse(double_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .long_active(long_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic string kname(input int k);
    case (k)
      EV_SINGLE: return "single";
      EV_DOUBLE: return "double";
      EV_LONG:   return "long";
      EV_REPEAT: return "repeat";
      EV_LA_ON:  return "active_rise";
      EV_LA_OFF: return "active_fall";
      default:   return "none";
    endcase
  endfunction

  function automatic logic [63:0] range_mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic expect_evt(input int kind, input int offset);
    evt_t e;
    e.kind  = kind;
    e.stamp = base + offset;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic actual, input logic required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
    end
  endtask

  // Bit e of each mask is the input value sampled at relative edge e.
  task automatic apply_stimulus(input int len, input logic [63:0] pmask,
                                input logic [63:0] lmask, input int rst_at);
    for (int e = 0; e < len; e++) begin
      rst         = (e == rst_at);
      btn_pressed = pmask[e];
      btn_level   = lmask[e];
      @(posedge clk);
      #1;
    end
    rst         = 1'b0;
    btn_pressed = 1'b0;
    btn_level   = 1'b0;
  endtask

  // Collect this cycle's events in a fixed order, then match against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      obs.delete();
      if (single_pulse === 1'b1) obs.push_back(EV_SINGLE);
      if (double_pulse === 1'b1) obs.push_back(EV_DOUBLE);
      if (long_pulse === 1'b1)   obs.push_back(EV_LONG);
      if (repeat_pulse === 1'b1) obs.push_back(EV_REPEAT);
      if (!$isunknown(long_active) && long_active != prev_la) begin
        obs.push_back(long_active ? EV_LA_ON : EV_LA_OFF);
        prev_la = long_active;
      end
      foreach (obs[i]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_event: got %s at edge %0d, expected no event",
                   kname(obs[i]), edge_cnt);
        end else begin
          evt_t e;
          e = exp_q.pop_front();
          if (e.kind != obs[i] || e.stamp != edge_cnt) begin
            bad++;
            $display("[TB] FAIL event_match: got %s at edge %0d, expected %s at edge %0d",
                     kname(obs[i]), edge_cnt, kname(e.kind), e.stamp);
          end
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    btn_pressed = 1'b0;
    btn_level   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_single", single_pulse, 1'b0);
    check_output("reset_double", double_pulse, 1'b0);
    check_output("reset_long", long_pulse, 1'b0);
    check_output("reset_repeat", repeat_pulse, 1'b0);
    check_output("reset_active", long_active, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    apply_stimulus(3, 64'd0, 64'd0, -1);

    // Short press then timeout: single click.
    base = edge_cnt + 1;
    expect_evt(EV_SINGLE, 7);
    apply_stimulus(14, 64'd1, range_mask(0, 2), -1);

    // Two short presses inside the gap: double click.
    base = edge_cnt + 1;
    expect_evt(EV_DOUBLE, 9);
    apply_stimulus(14, 64'd1 | (64'd1 << 5), range_mask(0, 2) | range_mask(5, 8), -1);

    // Long hold with repeats, silent release.
    base = edge_cnt + 1;
    expect_evt(EV_LONG, 8);
    expect_evt(EV_LA_ON, 8);
    expect_evt(EV_REPEAT, 12);
    expect_evt(EV_REPEAT, 16);
    expect_evt(EV_REPEAT, 20);
    expect_evt(EV_LA_OFF, 21);
    apply_stimulus(28, 64'd1, range_mask(0, 20), -1);

    // Release on the threshold edge beats long press.
    base = edge_cnt + 1;
    expect_evt(EV_SINGLE, 12);
    apply_stimulus(18, 64'd1, range_mask(0, 7), -1);

    // Second press on the last gap cycle is still a double.
    base = edge_cnt + 1;
    expect_evt(EV_DOUBLE, 9);
    apply_stimulus(14, 64'd1 | (64'd1 << 7), range_mask(0, 2) | range_mask(7, 8), -1);

    // Reset during LONG discards it; a fresh press starts over.
    base = edge_cnt + 1;
    expect_evt(EV_LONG, 8);
    expect_evt(EV_LA_ON, 8);
    expect_evt(EV_LA_OFF, 10);
    expect_evt(EV_LONG, 22);
    expect_evt(EV_LA_ON, 22);
    expect_evt(EV_LA_OFF, 23);
    apply_stimulus(30, 64'd1 | (64'd1 << 14), range_mask(0, 22), 10);

    // Spurious press pulses while held are ignored.
    base = edge_cnt + 1;
    expect_evt(EV_LONG, 8);
    expect_evt(EV_LA_ON, 8);
    expect_evt(EV_REPEAT, 12);
    expect_evt(EV_LA_OFF, 13);
    apply_stimulus(20, 64'd1 | (64'd1 << 3) | (64'd1 << 10), range_mask(0, 12), -1);

    // Press pulse with level already low: HELD1 then WAIT2 next edge.
    base = edge_cnt + 1;
    expect_evt(EV_SINGLE, 5);
    apply_stimulus(12, 64'd1, 64'd0, -1);

    // Reset in HELD1 discards the gesture entirely.
    apply_stimulus(14, 64'd1, range_mask(0, 5), 3);

    apply_stimulus(4, 64'd0, 64'd0, -1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drained: got %0d pending events, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
